// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared types and constants for the Debug Module abstract-command engine.
//   cmderr_e      : abstractcs.cmderr encoding
//   acmd_state_e  : abstract-command engine states
//   AARSIZE_32    : the only supported access size (32-bit)
//   GPR_* / DCSR_*: register-number landmarks of the debug register space
// -----------------------------------------------------------------------------
package dm_pkg;

    typedef enum logic [2:0] {
        NONE       = 3'd0,
        BUSY       = 3'd1,
        NOTSUP     = 3'd2,
        EXCEPT     = 3'd3,
        HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ACC = 2'd1,
        WR_ACC = 2'd2,
        DONE   = 2'd3
    } acmd_state_e;

    localparam logic [2:0]  AARSIZE_32 = 3'd2;

    localparam logic [15:0] GPR_BASE   = 16'h1000;
    localparam logic [15:0] GPR_LAST   = 16'h101F;
    localparam logic [15:0] DCSR_FIRST = 16'h07B0;
    localparam logic [15:0] DCSR_LAST  = 16'h07B3;

    // Anything up to the configured ceiling is forwarded to the register bus;
    // the responder decides what lives at each address.
    function automatic logic regno_supported(input logic [15:0] regno,
                                             input logic [15:0] regno_max);
        return regno <= regno_max;
    endfunction

endpackage

// File: rtl/dm_acmd_check.sv
// -----------------------------------------------------------------------------
// dm_acmd_check
// Combinational validation of an Access Register command. Produces the state
// the engine should enter and the error code (NONE when the command is good).
// Ports:
//   regno_i, aarsize_i, transfer_i, write_i : command fields
//   halted_i                                : hart halted status
//   next_state_o                            : IDLE on error, else DONE/RD_ACC/WR_ACC
//   err_o                                   : NONE, NOTSUP or HALTRESUME
// -----------------------------------------------------------------------------
module dm_acmd_check
    import dm_pkg::*;
#(
    parameter logic [15:0] REGNO_MAX = 16'h101F
) (
    input  logic [15:0]  regno_i,
    input  logic [2:0]   aarsize_i,
    input  logic         transfer_i,
    input  logic         write_i,
    input  logic         halted_i,
    output acmd_state_e  next_state_o,
    output cmderr_e      err_o
);

    always_comb begin
        next_state_o = IDLE;
        err_o        = NONE;
        if ((aarsize_i != AARSIZE_32) || !regno_supported(regno_i, REGNO_MAX)) begin
            err_o = NOTSUP;
        end else if (transfer_i && !halted_i) begin
            err_o = HALTRESUME;
        end else if (!transfer_i) begin
            // Nothing to move: complete without touching the bus.
            next_state_o = DONE;
        end else if (write_i) begin
            next_state_o = WR_ACC;
        end else begin
            next_state_o = RD_ACC;
        end
    end

endmodule

// File: rtl/dm_abstract_cmd.sv
// -----------------------------------------------------------------------------
// dm_abstract_cmd
// Abstract-command engine of the Debug Module. Accepts Access Register
// commands, performs one read or write on the debugger register bus and
// reports busy / cmderr for abstractcs.
// Ports:
//   clk_i, reset_i             : clock, synchronous active-high reset
//   cmd_valid_i, cmd_*_i       : command write pulse and its fields
//   halted_i                   : hart halted status
//   data0_i                    : data0 contents, used as write data
//   data0_o, data0_we_o        : read result and its one-cycle load strobe
//   cmderr_clr_i               : W1C pulse on cmderr
//   busy_o, cmderr_o           : abstractcs.busy / abstractcs.cmderr
//   dm_reg_rd_wr_address_o     : register bus address (holds last regno)
//   dm_reg_rd_wr_data_io       : shared tri-state data bus
//   dm_reg_rd_wr_en_o          : access strobe
//   dm_reg_rd_wr_o             : 1 = write, 0 = read
// -----------------------------------------------------------------------------
module dm_abstract_cmd
    import dm_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [15:0] REGNO_MAX    = 16'h101F
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    input  logic [15:0] cmd_regno_i,
    input  logic        cmd_write_i,
    input  logic        cmd_transfer_i,
    input  logic [2:0]  cmd_aarsize_i,
    input  logic        halted_i,
    input  logic [31:0] data0_i,
    output logic [31:0] data0_o,
    output logic        data0_we_o,
    input  logic        cmderr_clr_i,
    output logic        busy_o,
    output logic [2:0]  cmderr_o,
    output logic [15:0] dm_reg_rd_wr_address_o,
    inout  wire  [31:0] dm_reg_rd_wr_data_io,
    output logic        dm_reg_rd_wr_en_o,
    output logic        dm_reg_rd_wr_o
);

    if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
        $error("dm_abstract_cmd: READ_LATENCY must be within 1..7");
    end

    // Counter value in the final read-access cycle.
    localparam logic [2:0] LAST_RD_CNT = 3'(READ_LATENCY - 1);

    acmd_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    cmderr_e     cmderr_q, cmderr_d;

    acmd_state_e chk_state;
    cmderr_e     chk_err;

    dm_acmd_check #(
        .REGNO_MAX (REGNO_MAX)
    ) u_check (
        .regno_i      (cmd_regno_i),
        .aarsize_i    (cmd_aarsize_i),
        .transfer_i   (cmd_transfer_i),
        .write_i      (cmd_write_i),
        .halted_i     (halted_i),
        .next_state_o (chk_state),
        .err_o        (chk_err)
    );

    always_comb begin
        logic    err_set;
        cmderr_e err_new;

        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = 1'b0;
        err_set  = 1'b0;
        err_new  = NONE;

        case (state_q)
            // DONE also accepts a new command so back-to-back commands
            // lose no cycle.
            IDLE, DONE: begin
                state_d = IDLE;
                // A sticky error blocks every new command until cleared.
                if (cmd_valid_i && (cmderr_q == NONE)) begin
                    if (chk_err != NONE) begin
                        err_set = 1'b1;
                        err_new = chk_err;
                    end else begin
                        state_d = chk_state;
                        if (chk_state == RD_ACC || chk_state == WR_ACC) begin
                            addr_d  = cmd_regno_i;
                            wdata_d = data0_i;
                            cnt_d   = 3'd0;
                        end
                    end
                end
            end

            WR_ACC: begin
                state_d = DONE;
                if (cmd_valid_i && (cmderr_q == NONE)) begin
                    err_set = 1'b1;
                    err_new = BUSY;
                end
            end

            RD_ACC: begin
                if (cnt_q == LAST_RD_CNT) begin
                    rdata_d = dm_reg_rd_wr_data_io;
                    we_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
                if (cmd_valid_i && (cmderr_q == NONE)) begin
                    err_set = 1'b1;
                    err_new = BUSY;
                end
            end

            default: state_d = IDLE;
        endcase

        // A freshly raised error takes precedence over a same-cycle clear.
        if (err_set) begin
            cmderr_d = err_new;
        end else if (cmderr_clr_i) begin
            cmderr_d = NONE;
        end else begin
            cmderr_d = cmderr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= 16'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            we_q     <= 1'b0;
            cmderr_q <= NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            cmderr_q <= cmderr_d;
        end
    end

    // All outputs decode registered state only.
    assign busy_o                 = (state_q == RD_ACC) || (state_q == WR_ACC);
    assign dm_reg_rd_wr_en_o      = (state_q == RD_ACC) || (state_q == WR_ACC);
    assign dm_reg_rd_wr_o         = (state_q == WR_ACC);
    assign dm_reg_rd_wr_address_o = addr_q;
    assign data0_o                = rdata_q;
    assign data0_we_o             = we_q;
    assign cmderr_o               = cmderr_q;

    assign dm_reg_rd_wr_data_io   = (state_q == WR_ACC) ? wdata_q : 'z;

endmodule

// File: tb/tb_dm_abstract_cmd.sv
module tb_dm_abstract_cmd;

    localparam int          RL   = 3;
    localparam logic [15:0] RMAX = 16'h101F;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [15:0] cmd_regno;
    logic        cmd_write;
    logic        cmd_transfer;
    logic [2:0]  cmd_aarsize;
    logic        halted;
    logic [31:0] data0_in;
    logic [31:0] data0_out;
    logic        data0_we;
    logic        cmderr_clr;
    logic        busy;
    logic [2:0]  cmderr;
    logic [15:0] bus_addr;
    wire  [31:0] bus;
    logic        bus_en;
    logic        bus_rd_wr;

    // Responder / bus keeper: drives the bus except while the engine writes.
    logic [31:0] resp_data;
    logic        tb_drv;
    assign tb_drv = !(bus_en && bus_rd_wr);
    assign bus    = tb_drv ? resp_data : 'z;

    always #5 clk = ~clk;

    dm_abstract_cmd #(
        .READ_LATENCY (RL),
        .REGNO_MAX    (RMAX)
    ) u_dut (
        .clk_i                  (clk),
        .reset_i                (reset),
        .cmd_valid_i            (cmd_valid),
        .cmd_regno_i            (cmd_regno),
        .cmd_write_i            (cmd_write),
        .cmd_transfer_i         (cmd_transfer),
        .cmd_aarsize_i          (cmd_aarsize),
        .halted_i               (halted),
        .data0_i                (data0_in),
        .data0_o                (data0_out),
        .data0_we_o             (data0_we),
        .cmderr_clr_i           (cmderr_clr),
        .busy_o                 (busy),
        .cmderr_o               (cmderr),
        .dm_reg_rd_wr_address_o (bus_addr),
        .dm_reg_rd_wr_data_io   (bus),
        .dm_reg_rd_wr_en_o      (bus_en),
        .dm_reg_rd_wr_o         (bus_rd_wr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: a transaction is a number of remaining access cycles;
    // zero remaining means the engine can take a command.
    int          m_left;
    bit          m_read;
    int          m_cmderr;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    bit          m_we;

    function automatic void model_edge();
        bit new_err;
        int err_code;
        new_err  = 0;
        err_code = 0;
        if (reset) begin
            m_left = 0; m_read = 0; m_cmderr = 0; m_addr = 0;
            m_wdata = 0; m_rdata = 0; m_we = 0;
            return;
        end
        m_we = 0;
        if (m_left > 0) begin
            if (cmd_valid && m_cmderr == 0) begin
                new_err = 1; err_code = 1;
            end
            m_left--;
            if (m_left == 0 && m_read) begin
                m_we    = 1;
                m_rdata = resp_data;
            end
        end else if (cmd_valid && m_cmderr == 0) begin
            if (cmd_aarsize != 3'd2 || cmd_regno > RMAX) begin
                new_err = 1; err_code = 2;
            end else if (cmd_transfer && !halted) begin
                new_err = 1; err_code = 4;
            end else if (cmd_transfer) begin
                m_left  = cmd_write ? 1 : RL;
                m_read  = !cmd_write;
                m_addr  = cmd_regno;
                m_wdata = data0_in;
            end
        end
        if (new_err) m_cmderr = err_code;
        else if (cmderr_clr) m_cmderr = 0;
    endfunction

    task automatic compare();
        bit acc;
        acc = (m_left > 0);
        check_val("busy",   busy,      acc);
        check_val("en",     bus_en,    acc);
        check_val("rd_wr",  bus_rd_wr, acc && !m_read);
        check_val("addr",   bus_addr,  m_addr);
        check_val("we",     data0_we,  m_we);
        check_val("data0",  data0_out, m_rdata);
        check_val("cmderr", cmderr,    m_cmderr);
        check_val("bus",    bus,       (acc && !m_read) ? m_wdata : resp_data);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic issue(input logic [15:0] regno, input logic wr,
                         input logic xfer, input logic [2:0] size);
        cmd_valid    = 1'b1;
        cmd_regno    = regno;
        cmd_write    = wr;
        cmd_transfer = xfer;
        cmd_aarsize  = size;
        tick();
        cmd_valid    = 1'b0;
    endtask

    task automatic clear_err();
        cmderr_clr = 1'b1;
        tick();
        cmderr_clr = 1'b0;
    endtask

    function automatic logic [15:0] pick_regno();
        case ($urandom_range(0, 5))
            0:       return 16'h07B0 + 16'($urandom_range(0, 3));
            1:       return 16'h1000 + 16'($urandom_range(0, 31));
            2:       return 16'h101F;
            3:       return 16'h1020;
            4:       return 16'($urandom);
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_regno = '0; cmd_write = 1'b0;
        cmd_transfer = 1'b0; cmd_aarsize = 3'd2; halted = 1'b1;
        data0_in = '0; cmderr_clr = 1'b0; resp_data = '0;
        tick();
        tick();
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_cmderr", cmderr, 3'd0);
        reset = 1'b0;
        tick();

        // Write of DEADBEEF to a debug CSR
        data0_in = 32'hDEADBEEF;
        issue(16'h07B2, 1'b1, 1'b1, 3'd2);
        check_val("wr_bus", bus, 32'hDEADBEEF);
        check_val("wr_addr", bus_addr, 16'h07B2);
        tick();
        check_val("wr_busy_after", busy, 1'b0);
        tick();

        // Read of a GPR with RL access cycles
        resp_data = 32'h1234_5678;
        issue(16'h1005, 1'b0, 1'b1, 3'd2);
        repeat (RL) tick();
        check_val("rd_we", data0_we, 1'b1);
        check_val("rd_data", data0_out, 32'h1234_5678);
        resp_data = 32'h0;
        tick();

        // Unsupported size, sticky error, clear
        issue(16'h1001, 1'b0, 1'b1, 3'd3);
        check_val("notsup", cmderr, 3'd2);
        issue(16'h1001, 1'b1, 1'b1, 3'd2);
        check_val("ignored_busy", busy, 1'b0);
        clear_err();
        issue(16'h1001, 1'b1, 1'b1, 3'd2);
        check_val("after_clr_busy", busy, 1'b1);
        tick();

        // Regno just above the ceiling
        issue(16'h1020, 1'b0, 1'b1, 3'd2);
        check_val("regno_max", cmderr, 3'd2);
        clear_err();

        // Not halted
        halted = 1'b0;
        issue(16'h1002, 1'b0, 1'b1, 3'd2);
        check_val("haltresume", cmderr, 3'd4);
        halted = 1'b1;
        clear_err();

        // transfer = 0: no access
        issue(16'h1003, 1'b0, 1'b0, 3'd2);
        check_val("notransfer_busy", busy, 1'b0);
        tick();

        // Command during a read: busy error, read still completes
        resp_data = 32'hA5A5_0F0F;
        issue(16'h1010, 1'b0, 1'b1, 3'd2);
        issue(16'h1011, 1'b1, 1'b1, 3'd2);
        check_val("busy_err", cmderr, 3'd1);
        repeat (RL - 1) tick();
        check_val("busy_rd_we", data0_we, 1'b1);
        check_val("busy_rd_data", data0_out, 32'hA5A5_0F0F);
        clear_err();

        // Back-to-back: next command in the DONE cycle
        data0_in = 32'h0BAD_F00D;
        issue(16'h07B0, 1'b1, 1'b1, 3'd2);
        tick();
        issue(16'h07B1, 1'b0, 1'b1, 3'd2);
        check_val("b2b_busy", busy, 1'b1);
        check_val("b2b_cmderr", cmderr, 3'd0);
        repeat (RL + 1) tick();

        // Reset in the second read cycle
        issue(16'h1004, 1'b0, 1'b1, 3'd2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_mid_en", bus_en, 1'b0);
        check_val("rst_mid_we", data0_we, 1'b0);
        repeat (RL + 2) tick();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cmd_valid    = ($urandom_range(0, 3) == 0);
            cmd_regno    = pick_regno();
            cmd_write    = 1'($urandom);
            cmd_transfer = ($urandom_range(0, 7) != 0);
            cmd_aarsize  = ($urandom_range(0, 3) != 0) ? 3'd2 : 3'($urandom);
            halted       = ($urandom_range(0, 7) != 0);
            cmderr_clr   = ($urandom_range(0, 9) == 0);
            reset        = ($urandom_range(0, 199) == 0);
            data0_in     = $urandom;
            resp_data    = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_abstract_cmd.md
# dm_abstract_cmd

Debug Module abstract-command engine: the initiator side of the debugger register bus (`dm_reg_rd_wr_*`) that the core-side debug CSR/GPR block answers. It accepts Access Register commands from the DMI `command` register, validates them, and runs one read or write on the shared tri-state data bus. It returns read data to `data0` and maintains `busy`/`cmderr` for `abstractcs`.

## Interface
Parameters:
- READ_LATENCY, 1, cycles `dm_reg_rd_wr_en_o` is held high on a read before data is sampled; legal range 1–7.
- REGNO_MAX, 16'h101F, highest supported regno; anything above it is not supported.

Ports:
- clk_i  in  1  clock; single clock domain.
- reset_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  one-cycle pulse when DMI writes `command`.
- cmd_regno_i  in  16  command.regno.
- cmd_write_i  in  1  command.write; 1 = write to the hart register.
- cmd_transfer_i  in  1  command.transfer.
- cmd_aarsize_i  in  3  command.aarsize.
- halted_i  in  1  hart halted status.
- data0_i  in  32  current `data0` value, used as write data.
- data0_o  out  32  read result.
- data0_we_o  out  1  one-cycle strobe that loads `data0_o` into `data0`.
- cmderr_clr_i  in  1  W1C pulse on `abstractcs.cmderr`.
- busy_o  out  1  `abstractcs.busy`.
- cmderr_o  out  3  `abstractcs.cmderr`.
- dm_reg_rd_wr_address_o  out  16  register bus address (regno).
- dm_reg_rd_wr_data_io  inout  32  shared data bus.
- dm_reg_rd_wr_en_o  out  1  access strobe.
- dm_reg_rd_wr_o  out  1  1 = write, 0 = read.

## Operation
- **Reset values:** all outputs 0; data bus released to 'z; state IDLE.
- **States:** IDLE, RD_ACC, WR_ACC, DONE.
- **Acceptance.** A command on `cmd_valid_i` in IDLE is checked in this priority order:
  - `cmderr_o != 0`: ignore the command; no state change.
  - `aarsize != 3'd2` or `regno > REGNO_MAX`: cmderr = 2 (not supported).
  - `transfer` = 1 and `halted_i` = 0: cmderr = 4 (halt/resume).
  - `transfer` = 0: go to DONE with no bus access.
  - Otherwise go to WR_ACC or RD_ACC according to `cmd_write_i`.
- **Rejected commands** never raise `busy_o`.
- **`cmd_valid_i` while busy:** cmderr = 1 (busy) only if cmderr is currently 0. The in-flight access completes normally.
- **WR_ACC:**
  - `en` = 1, `rd_wr` = 1, `address` = regno, for exactly 1 cycle.
  - The bus is driven with `data0_i` as latched at acceptance.
  - Then go to DONE.
- **RD_ACC:**
  - `en` = 1, `rd_wr` = 0, bus released, for READ_LATENCY cycles; a 3-bit counter tracks them.
  - The bus is sampled on the clock edge that ends the last cycle.
  - Then go to DONE.
- **DONE:**
  - 1 cycle; `busy_o` = 0 in this cycle.
  - After a read, `data0_we_o` = 1 and `data0_o` = the sampled value.
  - Return to IDLE.
- **Bus driving:** the bus is driven only in the WR_ACC cycle and is 'z in every other cycle.
- **`dm_reg_rd_wr_address_o`** holds the last regno between accesses.
- **cmderr updates:**
  - `cmderr_clr_i` clears cmderr to 0.
  - If a clear and a new error occur in the same cycle, the new error wins.

## Timing
- Command accepted at edge T. `busy_o`, `en` and the address are valid from cycle T+1.
- **Write:** `en` is high in cycle T+1 only; `busy_o` is high in cycle T+1 only.
- **Read:** `en` is high in cycles T+1 … T+READ_LATENCY. `data0_we_o` pulses and `busy_o` falls in cycle T+READ_LATENCY+1.
- **transfer = 0:** `busy_o` is never asserted; completes with zero access cycles.
- **Back-to-back commands:** the earliest next `cmd_valid_i` that is accepted without a busy error arrives in the DONE cycle. That command is accepted, since DONE → IDLE check is combined.
- **Reset mid-access:** on the next edge `en` = 0, the bus is released, busy = 0, cmderr = 0, and no `data0_we_o` occurs.
- **No combinational paths** from any input to any output, except the tri-state enable, which is registered state.

## Structure
- **Shared package `dm_pkg`** holds:
  - `cmderr_e` enum (NONE = 0, BUSY = 1, NOTSUP = 2, EXCEPT = 3, HALTRESUME = 4).
  - `acmd_state_e` enum.
  - `AARSIZE_32 = 3'd2`.
  - Regno range constants: GPR base 16'h1000, debug CSR range 16'h07B0–16'h07B3.
- **One natural sub-module: `dm_acmd_check`.** It is combinational validation of regno/aarsize/halted/transfer and returns the next state plus the error code. The FSM, counter, latches and tri-state driver stay in `dm_abstract_cmd`.

## Test plan
- **Write:** halted = 1, write regno 16'h07B2, `data0_i` = 32'hDEADBEEF → one cycle of `en` = 1, `rd_wr` = 1, bus = DEADBEEF; bus is 'z before and after; busy high 1 cycle; cmderr = 0.
- **Read:** READ_LATENCY = 3, responder drives 32'h1234_5678 on 16'h1005 → `en` high 3 cycles; `data0_we_o` pulses with 1234_5678 in the 4th cycle after acceptance.
- **Errors:**
  - aarsize = 3 → cmderr = 2, no bus activity.
  - Then a valid command → ignored.
  - Then `cmderr_clr_i` → cmderr = 0, and the next command runs.
- **Not halted / busy:**
  - halted = 0, transfer = 1 → cmderr = 4.
  - Command issued during a read's `en` window → cmderr = 1, and the read still completes with a `data0_we_o` pulse.
- **Reset during RD_ACC** (READ_LATENCY = 5, reset in 2nd cycle) → next cycle all outputs 0, bus 'z, no `data0_we_o` pulse.
